div_seq_ctrl: RTL
=================

Name:
div_seq_ctrl

Overview:
FSM controller that sequences a DW-bit restoring shift-subtract divider datapath.
- Accepts a start/ready request and runs a one-cycle operand load.
- Runs DW shift/subtract iterations, steering the datapath's restore mux and quotient bit from the sign of the trial subtraction.
- Presents done/err until the consumer acknowledges.
- Owns the iteration counter; sits between the top-level command interface and the divider datapath/register file.

Parameters:
DW, 16, dividend/divisor width and iteration count; legal range DW >= 2.
CW, $clog2(DW), iteration counter width; must hold DW-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous, active-low (rst==0 sampled at posedge clk resets the block)
start  input  1  request a division; sampled only in IDLE
div_zero  input  1  datapath flag: divisor operand == 0, valid while start is high
sub_neg  input  1  datapath flag: trial (remainder - divisor) is negative, valid during ITER
out_ack  input  1  consumer accepts result/error
ready  output  1  high in IDLE only
busy  output  1  high in LOAD and ITER
load  output  1  datapath operand capture and remainder clear; high in LOAD only
shift_en  output  1  datapath shift/iterate enable; high in ITER only
restore  output  1  = sub_neg & (state==ITER); selects the un-subtracted remainder
quot_bit  output  1  = ~sub_neg & (state==ITER); bit shifted into the quotient
iter_cnt  output  CW  current iteration index, 0..DW-1
done  output  1  result valid; high in DONE and ERR
err_div0  output  1  divide-by-zero; high in ERR only

Behaviour:
- States: IDLE, LOAD, ITER, DONE, ERR. Binary-encoded state register.
- Reset (rst==0 at an edge) forces the following, regardless of current state, including mid-operation; the in-flight division is discarded:
  - state=IDLE, iter_cnt=0.
  - Next cycle: ready=1, all other outputs 0.
- IDLE:
  - start=1 & div_zero=1 -> ERR.
  - start=1 & div_zero=0 -> LOAD.
  - start=0 -> stay.
- LOAD: exactly one cycle; iter_cnt<=0; -> ITER.
- ITER:
  - shift_en=1 every cycle.
  - iter_cnt==DW-1 -> DONE, iter_cnt<=0.
  - Otherwise iter_cnt<=iter_cnt+1.
  - Exactly DW ITER cycles per division.
- DONE / ERR: hold until out_ack=1, then -> IDLE.
- out_ack outside DONE/ERR is ignored.
- start outside IDLE is ignored; there is no queuing.
- Latency: start sampled at edge N -> LOAD in cycle N+1 -> ITER in cycles N+2..N+DW+1 -> done=1 from cycle N+DW+2. DW=16: 18 cycles.
- Divide-by-zero: done=1 and err_div0=1 in cycle N+1. No load/shift pulses are issued.
- Back-to-back operation: out_ack and start high in consecutive cycles -> IDLE for one cycle, then LOAD. Minimum issue interval is DW+3 cycles.
- All outputs except restore/quot_bit are decoded from registered state/counter only (Moore). restore/quot_bit are combinational from sub_neg, gated by ITER.

Optional Feature:
DIV_ABORT_EN
- Defined:
  - Adds port abort (input, 1).
  - abort=1 in LOAD or ITER -> IDLE next edge, iter_cnt<=0, no done pulse.
  - abort in IDLE/DONE/ERR is ignored.
  - rst has priority over abort.
- Not defined: port absent; LOAD/ITER always run to completion.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> ready=1, busy=0, done=0, iter_cnt=0 after release; no LOAD entered while rst=0.
- Nominal, DW=16: pulse start (div_zero=0), drive sub_neg pattern 1010... -> load=1 for 1 cycle, shift_en high 16 cycles, quot_bit = ~sub_neg per cycle, done=1 exactly 18 cycles after start, held until out_ack.
- Div-by-zero: start=1, div_zero=1 -> next cycle done=1 and err_div0=1, load/shift_en never asserted; out_ack -> IDLE, ready=1.
- Mid-op reset: rst=0 at iter_cnt=7 -> next cycle IDLE, iter_cnt=0, shift_en=0; subsequent division completes normally in 18 cycles.
- Ignored inputs: start pulsed during ITER and out_ack pulsed during ITER -> no change to iter_cnt sequence or done timing.
- DIV_ABORT_EN defined: abort at iter_cnt=3 -> IDLE next cycle, done never asserted; abort while in DONE -> done held until out_ack.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencing FSM for a DW-bit restoring shift/subtract divider datapath.
// Optional macro DIV_ABORT_EN adds an abort input that cancels LOAD/ITER.
module div_seq_ctrl #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          div_zero,
    input  logic          sub_neg,
    input  logic          out_ack,
`ifdef DIV_ABORT_EN
    input  logic          abort,
`endif
    output logic          ready,
    output logic          busy,
    output logic          load,
    output logic          shift_en,
    output logic          restore,
    output logic          quot_bit,
    output logic [CW-1:0] iter_cnt,
    output logic          done,
    output logic          err_div0
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  flags;
    logic        abort_req;
    logic        last_iter;

`ifdef DIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_iter = (iter_cnt == CW'(DW - 1));

    // Moore flags per state, packed as {ready, busy, load, shift_en, done, err_div0}
    function automatic logic [5:0] decode(input state_t s);
        case (s)
            IDLE:    decode = 6'b100000;
            LOAD:    decode = 6'b011000;
            ITER:    decode = 6'b010100;
            DONE:    decode = 6'b000010;
            ERR:     decode = 6'b000011;
            default: decode = 6'b100000;
        endcase
    endfunction

    // Flags are registered alongside the state so every Moore output is glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            flags    <= decode(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (start && div_zero) begin
                        state <= ERR;
                        flags <= decode(ERR);
                    end else if (start) begin
                        state <= LOAD;
                        flags <= decode(LOAD);
                    end
                end
                LOAD: begin
                    iter_cnt <= '0;
                    if (abort_req) begin
                        state <= IDLE;
                        flags <= decode(IDLE);
                    end else begin
                        state <= ITER;
                        flags <= decode(ITER);
                    end
                end
                ITER: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        iter_cnt <= '0;
                        flags    <= decode(IDLE);
                    end else if (last_iter) begin
                        state    <= DONE;
                        iter_cnt <= '0;
                        flags    <= decode(DONE);
                    end else begin
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                DONE, ERR: begin
                    if (out_ack) begin
                        state <= IDLE;
                        flags <= decode(IDLE);
                    end
                end
                default: begin
                    state    <= IDLE;
                    iter_cnt <= '0;
                    flags    <= decode(IDLE);
                end
            endcase
        end
    end

    assign {ready, busy, load, shift_en, done, err_div0} = flags;

    // Restore/quotient steering must follow sub_neg in the same cycle, so only these are combinational.
    assign restore  = sub_neg & shift_en;
    assign quot_bit = ~sub_neg & shift_en;

endmodule
